// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - row-scanning keypad controller with debounce FSM and key-event FIFO
module keypad_scanner #(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int SCAN_DIV   = 50000,
  parameter  int DEBOUNCE   = 3,
  parameter  int FIFO_DEPTH = 4,
  localparam int KW         = $clog2(ROWS*COLS)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [ROWS-1:0] row,
  input  logic [COLS-1:0] col,
  output logic          key_valid,
  input  logic          key_ready,
  output logic [KW-1:0] key_code,
  output logic          key_held,
  output logic          overflow
);

  localparam int NK   = ROWS * COLS;
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(DEBOUNCE + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CW-1:0]   DEB        = CW'(DEBOUNCE);
  localparam logic [CNTW-1:0] FIFO_FULL  = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRESS_DB, S_HELD, S_REL_DB} state_t;

  // Registers
  logic [COLS-1:0] col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [ROWS-1:0] row_q, row_d;
  logic [NK-1:0]   frame_q, frame_d;
  state_t          state_q, state_d;
  logic [CW-1:0]   dbc_q, dbc_d;
  logic [KW-1:0]   cand_q, cand_d;
  logic            key_held_q, key_held_d;
  logic [KW-1:0]   mem_q [FIFO_DEPTH];
  logic [KW-1:0]   mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            key_valid_q, key_valid_d;
  logic [KW-1:0]   key_code_q, key_code_d;
  logic            overflow_q, overflow_d;

  // Combinational helpers
  logic            dwell_last, frame_end;
  logic [NK-1:0]   frame_now;
  logic            any_key, multi_key, cls_none, cls_one;
  logic [KW-1:0]   hit_code;
  logic [CW-1:0]   dbc_inc;
  logic            push, pop, full, push_ok;

  assign row       = row_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign overflow  = overflow_q;

  // Column synchronizer, row scan timing and frame image accumulation
  always_comb begin
    col_s1_d   = col;
    col_s2_d   = col_s1_q;
    dwell_last = (dwell_q == DWELL_LAST);
    frame_end  = dwell_last && (row_idx_q == ROW_LAST);
    dwell_d    = dwell_last ? '0 : dwell_q + DW'(1);
    row_idx_d  = row_idx_q;
    if (dwell_last) begin
      row_idx_d = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + RW'(1);
    end
    row_d = ~(ROWS'(1) << row_idx_d);
    // Image including the sample taken this cycle, so the last row is seen at frame end
    frame_now = frame_q;
    if (dwell_last) begin
      frame_now[int'(row_idx_q)*COLS +: COLS] = ~col_s2_q;
    end
    frame_d = frame_end ? '0 : frame_now;
  end

  // Classify the frame image as no key, exactly one key (with code) or several keys
  always_comb begin
    any_key   = 1'b0;
    multi_key = 1'b0;
    hit_code  = '0;
    for (int i = 0; i < NK; i++) begin
      if (frame_now[i]) begin
        if (any_key) multi_key = 1'b1;
        any_key  = 1'b1;
        hit_code = KW'(i);
      end
    end
    cls_none = !any_key;
    cls_one  = any_key && !multi_key;
  end

  // Debounce FSM, advanced once per frame
  always_comb begin
    state_d = state_q;
    dbc_d   = dbc_q;
    cand_d  = cand_q;
    push    = 1'b0;
    dbc_inc = dbc_q + CW'(1);
    if (frame_end) begin
      case (state_q)
        S_IDLE: begin
          if (cls_one) begin
            state_d = S_PRESS_DB;
            cand_d  = hit_code;
            dbc_d   = CW'(1);
          end
        end
        S_PRESS_DB: begin
          if (cls_one && (hit_code == cand_q)) begin
            if (dbc_inc == DEB) begin
              push    = 1'b1;
              state_d = S_HELD;
              dbc_d   = '0;
            end else begin
              dbc_d = dbc_inc;
            end
          end else if (cls_one) begin
            cand_d = hit_code;
            dbc_d  = CW'(1);
          end else begin
            state_d = S_IDLE;
            dbc_d   = '0;
          end
        end
        S_HELD: begin
          if (cls_none) begin
            state_d = S_REL_DB;
            dbc_d   = CW'(1);
          end
        end
        S_REL_DB: begin
          if (cls_none) begin
            if (dbc_inc == DEB) begin
              state_d = S_IDLE;
              dbc_d   = '0;
            end else begin
              dbc_d = dbc_inc;
            end
          end else begin
            state_d = S_HELD;
            dbc_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    key_held_d = (state_d == S_HELD) || (state_d == S_REL_DB);
  end

  // Event FIFO; a push on a full FIFO is only accepted when a pop frees the head slot
  always_comb begin
    pop        = key_valid_q && key_ready;
    full       = (count_q == FIFO_FULL);
    push_ok    = push && (!full || pop);
    overflow_d = push && full && !pop;
    mem_d      = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = cand_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    key_valid_d = (count_d != '0);
    key_code_d  = mem_d[rd_ptr_d];
  end

  // State registers; synchronizer resets to the idle (released) column level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_s1_q    <= '1;
      col_s2_q    <= '1;
      dwell_q     <= '0;
      row_idx_q   <= '0;
      row_q       <= '1;
      frame_q     <= '0;
      state_q     <= S_IDLE;
      dbc_q       <= '0;
      cand_q      <= '0;
      key_held_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      col_s1_q    <= col_s1_d;
      col_s2_q    <= col_s2_d;
      dwell_q     <= dwell_d;
      row_idx_q   <= row_idx_d;
      row_q       <= row_d;
      frame_q     <= frame_d;
      state_q     <= state_d;
      dbc_q       <= dbc_d;
      cand_q      <= cand_d;
      key_held_q  <= key_held_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - frame-table and directed-sequence bench for keypad_scanner
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic        key_ready;
  logic [3:0]  key_code;
  logic        key_held;
  logic        overflow;
  logic [15:0] keys;

  typedef struct {
    logic [15:0] keys;
    logic        rdy;
    logic        v;
    logic [3:0]  code;
    logic        h;
    logic        o;
  } vec_t;

  vec_t tbl[$];
  int   events[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its column low while its row is driven low
  always_comb begin
    col = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
  end

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_code  (key_code),
    .key_held  (key_held),
    .overflow  (overflow)
  );

  // Record each handshake; the pop happens at the following rising edge
  always @(negedge clk)
    if (reset_n === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1)
      events.push_back(int'(key_code));

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [15:0] kbit(input int code);
    logic [15:0] one;
    one = 16'd1;
    return one << code;
  endfunction

  function automatic void add(input logic [15:0] k, input logic r, input logic v,
                              input logic [3:0] c, input logic h, input logic o);
    vec_t e;
    e.keys = k; e.rdy = r; e.v = v; e.code = c; e.h = h; e.o = o;
    tbl.push_back(e);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_events(input string name, input int exp[$]);
    check({name, " count"}, events.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < events.size()) check($sformatf("%s[%0d]", name, i), events[i], exp[i]);
  endtask

  // One full scan frame (16 cycles); returns 1 time unit after the frame-end edge
  task automatic run_frame(input logic [15:0] k);
    keys = k;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic press_release(input int code);
    for (int f = 0; f < 3; f++) run_frame(kbit(code));
    for (int f = 0; f < 3; f++) run_frame(16'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " row"}, int'(row), 15);
    check({tag, " key_valid"}, int'(key_valid), 0);
    check({tag, " key_code"}, int'(key_code), 0);
    check({tag, " key_held"}, int'(key_held), 0);
    check({tag, " overflow"}, int'(overflow), 0);
  endtask

  initial begin
    int codes4[5];
    int exp_q[$];
    codes4 = '{1, 2, 3, 4, 6};
    reset_n = 1'b0; key_ready = 1'b0; keys = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Single key 9 held 5 frames then released, consumer always ready
    for (int f = 0; f < 5; f++) add(kbit(9), 1'b1, f == 2, 4'd9, f >= 2, 1'b0);
    for (int f = 0; f < 3; f++) add(16'd0, 1'b1, 1'b0, 4'd0, f < 2, 1'b0);
    // Key 7 bounces: 2 frames, release, 2 frames, release -> nothing
    add(kbit(7), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    add(kbit(7), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    add(16'd0,   1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    add(kbit(7), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    add(kbit(7), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    add(16'd0,   1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    // Keys 0 and 5 together for 6 frames -> nothing
    for (int f = 0; f < 6; f++) add(kbit(0) | kbit(5), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    add(16'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    // Five debounced presses with consumer stalled; fifth overflows
    for (int i = 0; i < 5; i++)
      for (int f = 0; f < 6; f++)
        add(f < 3 ? kbit(codes4[i]) : 16'd0, 1'b0, (i > 0) || (f >= 2), 4'd1,
            (f >= 2) && (f < 5), (i == 4) && (f == 2));

    events.delete();
    foreach (tbl[i]) begin
      key_ready = tbl[i].rdy;
      run_frame(tbl[i].keys);
      check($sformatf("vec%0d key_valid", i), int'(key_valid), int'(tbl[i].v));
      if (tbl[i].v) check($sformatf("vec%0d key_code", i), int'(key_code), int'(tbl[i].code));
      check($sformatf("vec%0d key_held", i), int'(key_held), int'(tbl[i].h));
      check($sformatf("vec%0d overflow", i), int'(overflow), int'(tbl[i].o));
    end
    exp_q = '{9};
    check_events("single_event", exp_q);

    // Drain the stalled FIFO
    events.delete();
    key_ready = 1'b1;
    run_frame(16'd0);
    key_ready = 1'b0;
    check("drain key_valid", int'(key_valid), 0);
    exp_q = '{1, 2, 3, 4};
    check_events("drain", exp_q);

    // Refill to full, then push 7 while popping in the same frame-end cycle
    for (int c = 10; c < 14; c++) press_release(c);
    check("full key_valid", int'(key_valid), 1);
    check("full key_code", int'(key_code), 10);
    events.delete();
    keys = kbit(7);
    repeat (32) @(posedge clk);
    repeat (15) @(posedge clk);
    #1 key_ready = 1'b1;
    @(posedge clk);
    #1 key_ready = 1'b0;
    check("push_pop overflow", int'(overflow), 0);
    check("push_pop key_held", int'(key_held), 1);
    check("push_pop key_code", int'(key_code), 11);
    exp_q = '{10};
    check_events("push_pop popped", exp_q);
    for (int f = 0; f < 3; f++) run_frame(16'd0);
    events.delete();
    key_ready = 1'b1;
    run_frame(16'd0);
    key_ready = 1'b0;
    exp_q = '{11, 12, 13, 7};
    check_events("push_pop drain", exp_q);

    // Two queued events, then reset in the middle of debouncing key 2
    press_release(14);
    press_release(15);
    check("pre_reset key_code", int'(key_code), 14);
    run_frame(kbit(2));
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    events.delete();
    reset_n = 1'b1;
    @(posedge clk);
    #1 check("post_reset row", int'(row), 14);
    repeat (15) @(posedge clk);
    #1 check("post_reset f1 key_valid", int'(key_valid), 0);
    run_frame(kbit(2));
    check("post_reset f2 key_valid", int'(key_valid), 0);
    run_frame(kbit(2));
    check("post_reset f3 key_valid", int'(key_valid), 1);
    check("post_reset f3 key_code", int'(key_code), 2);
    check("post_reset f3 key_held", int'(key_held), 1);
    check("post_reset events", events.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4: number of keypad row lines driven by the block (2..8).
REQ-002 Parameter COLS, default 4: number of keypad column lines sampled by the block (2..8).
REQ-003 Parameter SCAN_DIV, default 50000: clk cycles each row is driven (dwell); minimum 4.
REQ-004 Parameter DEBOUNCE, default 3: consecutive identical frames required to accept a press or release; minimum 2.
REQ-005 Parameter FIFO_DEPTH, default 4: key-event FIFO entries; power of 2, minimum 2.
REQ-006 Derived KW = clog2(ROWS*COLS): key code width.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  system clock.
REQ-009 reset_n  in  1  asynchronous active-low reset.
REQ-010 row  out  ROWS  row drive, active-low one-hot; registered.
REQ-011 col  in  COLS  column sense, active-low (external pull-ups), asynchronous.
REQ-012 key_valid  out  1  FIFO non-empty; key_code is valid.
REQ-013 key_ready  in  1  consumer accepts head entry.
REQ-014 key_code  out  KW  head entry, code = row_index*COLS + col_index.
REQ-015 key_held  out  1  high while the FSM is in HELD or REL_DB.
REQ-016 overflow  out  1  one-cycle pulse when an event is dropped on a full FIFO.

Function
REQ-017 col SHALL pass through a 2-flop synchronizer before any use.
REQ-018 Dwell counter counts 0..SCAN_DIV-1; at terminal count the row index advances modulo ROWS and row = ~(1<<row_index) in the next cycle.
REQ-019 Synchronized col SHALL be sampled in the final dwell cycle of each row into a ROWS*COLS frame image.
REQ-020 Frame end = final dwell cycle of row ROWS-1; the frame image SHALL then be classified as NONE (0 keys), ONE (exactly 1 key, with its code) or MULTI (>=2 keys).
REQ-021 The frame image SHALL be cleared at frame end; the classification is evaluated only at frame end.
REQ-022 FSM states IDLE, PRESS_DB, HELD, REL_DB; debounce counter dbc; candidate register cand.
REQ-023 IDLE: ONE -> PRESS_DB, cand=code, dbc=1; NONE/MULTI -> stay.
REQ-024 PRESS_DB: ONE with code==cand -> dbc+1; when dbc+1==DEBOUNCE, push cand and go HELD.
REQ-025 PRESS_DB: ONE with code!=cand -> stay, cand=code, dbc=1; NONE or MULTI -> IDLE.
REQ-026 HELD: NONE -> REL_DB, dbc=1; ONE/MULTI -> stay (no repeat events).
REQ-027 REL_DB: NONE -> dbc+1; when dbc+1==DEBOUNCE -> IDLE; ONE/MULTI -> HELD.
REQ-028 The push SHALL occur in the frame-end cycle; key_valid rises in the following cycle when the FIFO was empty.
REQ-029 Pop occurs when key_valid && key_ready; key_code and key_valid are FIFO head/state, registered.
REQ-030 Push to a full FIFO without a simultaneous pop: event dropped, contents unchanged, overflow=1 next cycle.
REQ-031 Push and pop in the same cycle on a full FIFO: both accepted, count unchanged, no overflow.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order is strictly first-in first-out.
REQ-033 key_ready while key_valid=0 SHALL have no effect.

Reset
REQ-034 While reset_n=0: row=all ones, key_valid=0, key_code=0, key_held=0, overflow=0, FSM=IDLE, dbc=0, cand=0, dwell and row index=0, FIFO empty, synchronizer and frame image cleared.
REQ-035 Reset asserted mid-debounce or mid-frame SHALL discard the partial frame, pending candidate and all FIFO contents.
REQ-036 After reset_n rises, row = ~1 (row 0 driven) on the first clk edge and scanning proceeds from row 0.

Verification
(ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3, FIFO_DEPTH=4; frame=16 cycles)
REQ-037 Hold key row2/col1 for 5 frames, key_ready=1 -> exactly one event, key_code=9, key_valid high one cycle after frame 3 end; key_held=1 from then until 3 NONE frames after release.
REQ-038 Key row1/col3 pressed 2 frames then released -> no event, FSM returns to IDLE.
REQ-039 Keys 0 and 5 held together 6 frames -> no event; key_held=0.
REQ-040 key_ready=0, five distinct debounced presses (codes 1,2,3,4,6) -> FIFO holds 1,2,3,4; overflow pulses once on the fifth; draining yields 1,2,3,4 then key_valid=0.
REQ-041 FIFO full, key_ready=1 in the frame-end cycle of a new press (code 7) -> no overflow, 7 appears as fourth entry.
REQ-042 reset_n pulsed low during PRESS_DB with 2 entries in FIFO -> all outputs at REQ-034 values; no event until 3 fresh frames of a key.
